// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Turns a simple valid/ready command interface into single APB transfers
// (one outstanding transfer at a time). It also returns a one-cycle response
// pulse that carries the read data and an error flag.
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   When defined, a counter tracks ACCESS-phase cycles. A transfer whose slave
//   has not raised tim_pready within TIMEOUT_CYC ACCESS cycles is aborted. It
//   then responds with rsp_err=1 and rsp_timeout=1.
//   When undefined, ACCESS waits indefinitely and rsp_timeout is tied to 0.
//
// Parameters
//   TIMEOUT_CYC  maximum ACCESS cycles before abort (APB_TIMEOUT_EN only)
//
// Ports
//   sys_clk      single clock, rising edge
//   sys_rst      asynchronous active-high reset
//   cmd_valid    command request
//   cmd_ready    command accepted when high together with cmd_valid
//   cmd_write    1 = write, 0 = read
//   cmd_addr     byte address (must be word aligned)
//   cmd_wdata    write data
//   cmd_strb     write byte strobes
//   rsp_valid    one-cycle response pulse
//   rsp_rdata    read data, held until the next read response
//   rsp_err      slave error, misaligned address or timeout
//   rsp_timeout  response caused by timeout
//   tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
//                APB request signals (registered)
//   tim_prdata, tim_pready, tim_pslverr
//                APB completion signals from the slave
// ---------------------------------------------------------------------------
module apb_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  // response side
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // APB side
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [31:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

  // NOTE: cmd_ready is decoded from the state register and not registered
  // separately. That keeps it low while reset is held and high in the very
  // first cycle after release. A separate flop would add a dead cycle.
  assign cmd_ready = (state == IDLE) && !sys_rst;

`ifdef APB_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYC-1, the last index of an ACCESS cycle.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] access_cnt;
  logic             rsp_timeout_q;

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // NOTE: every state and output register below is written with non-blocking
  // assignments in this one clocked block. All outputs therefore update together
  // on the edge and are free of combinational glitches. The block has no
  // combinational process, so it can infer no latch.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      tim_pstrb   <= '0;
`ifdef APB_TIMEOUT_EN
      access_cnt    <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      // Default: the response pulse lasts a single cycle.
      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr[1:0] != 2'b00) begin
              // A misaligned request never reaches the bus. It only reports
              // an error, and rsp_rdata keeps its previous value.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
`ifdef APB_TIMEOUT_EN
              rsp_timeout_q <= 1'b0;
`endif
            end else begin
              // The command is copied into the APB registers here. Later
              // activity on cmd_* cannot disturb this transfer.
              state      <= SETUP;
              tim_psel   <= 1'b1;
              tim_paddr  <= cmd_addr;
              tim_pwrite <= cmd_write;
              tim_pwdata <= cmd_write ? cmd_wdata : '0;
              tim_pstrb  <= cmd_write ? cmd_strb  : '0;
`ifdef APB_TIMEOUT_EN
              access_cnt <= '0;
`endif
            end
          end
        end

        SETUP: begin
          state       <= ACCESS;
          tim_penable <= 1'b1;
        end

        ACCESS: begin
          // tim_pslverr and tim_prdata are only sampled together with
          // tim_pready.
          if (tim_pready) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_err     <= tim_pslverr;
            if (!tim_pwrite) begin
              rsp_rdata <= tim_prdata;
            end
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= '0;
            tim_pwdata  <= '0;
            tim_pstrb   <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (access_cnt == CNT_LAST) begin
            // The last allowed ACCESS cycle passed without tim_pready.
            // Abandon the transfer. A tim_pready that arrives later is not
            // observed because the FSM has already left ACCESS.
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_timeout_q <= 1'b1;
            tim_psel      <= 1'b0;
            tim_penable   <= 1'b0;
            tim_pwrite    <= 1'b0;
            tim_paddr     <= '0;
            tim_pwdata    <= '0;
            tim_pstrb     <= '0;
          end else begin
            access_cnt <= access_cnt + 1'b1;
`endif
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Directed, self-checking bench for apb_master. It is built with
// TIMEOUT_CYC=4. When APB_TIMEOUT_EN is defined, the stalled-slave step
// expects an abort after 4 ACCESS cycles. Otherwise that step expects the
// transfer to keep waiting until the slave finally answers.
// ---------------------------------------------------------------------------
module tb_apb_master;

  logic        sys_clk;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [31:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata;
  logic        tim_pready;
  logic        tim_pslverr;

  int checks;
  int failures;

  apb_master #(.TIMEOUT_CYC(4)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .tim_psel    (tim_psel),
    .tim_penable (tim_penable),
    .tim_pwrite  (tim_pwrite),
    .tim_paddr   (tim_paddr),
    .tim_pwdata  (tim_pwdata),
    .tim_pstrb   (tim_pstrb),
    .tim_prdata  (tim_prdata),
    .tim_pready  (tim_pready),
    .tim_pslverr (tim_pslverr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge. Stimulus is driven
  // and outputs are sampled at that point.
  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_strb  = strb;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, " psel"},    tim_psel,    1'b0);
    check({tag, " penable"}, tim_penable, 1'b0);
    check({tag, " paddr"},   tim_paddr,   32'h0);
    check({tag, " pwdata"},  tim_pwdata,  32'h0);
    check({tag, " pstrb"},   tim_pstrb,   4'h0);
    check({tag, " pwrite"},  tim_pwrite,  1'b0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    sys_rst     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 32'h0;
    cmd_wdata   = 32'h0;
    cmd_strb    = 4'h0;
    tim_prdata  = 32'h0;
    tim_pready  = 1'b0;
    tim_pslverr = 1'b0;

    // ---------------- reset state ----------------
    cycle();
    cycle();
    check("rst cmd_ready", cmd_ready, 1'b0);
    check("rst rsp_valid", rsp_valid, 1'b0);
    check("rst rsp_err",   rsp_err,   1'b0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check_idle_bus("rst");
    sys_rst = 1'b0;
    #1;
    check("rel cmd_ready", cmd_ready, 1'b1);

    // ---------------- zero-wait write ----------------
    tim_pready = 1'b1;
    issue(1'b1, 32'h4000_1004, 32'hA5A5_5A5A, 4'hF);
    cycle();  // accepted -> SETUP
    cmd_valid = 1'b0;
    cmd_addr  = 32'hDEAD_0000;
    cmd_wdata = 32'h1234_5678;
    check("wr setup psel",    tim_psel,    1'b1);
    check("wr setup penable", tim_penable, 1'b0);
    check("wr setup paddr",   tim_paddr,   32'h4000_1004);
    check("wr setup pwrite",  tim_pwrite,  1'b1);
    check("wr setup pwdata",  tim_pwdata,  32'hA5A5_5A5A);
    check("wr setup pstrb",   tim_pstrb,   4'hF);
    check("wr setup ready",   cmd_ready,   1'b0);
    cycle();  // ACCESS
    check("wr access psel",    tim_psel,    1'b1);
    check("wr access penable", tim_penable, 1'b1);
    check("wr access paddr",   tim_paddr,   32'h4000_1004);
    check("wr access pwdata",  tim_pwdata,  32'hA5A5_5A5A);
    check("wr access rvalid",  rsp_valid,   1'b0);
    cycle();  // RESP
    check("wr resp valid", rsp_valid,   1'b1);
    check("wr resp err",   rsp_err,     1'b0);
    check("wr resp tout",  rsp_timeout, 1'b0);
    check("wr resp rdata", rsp_rdata,   32'h0);
    check("wr resp ready", cmd_ready,   1'b0);
    check_idle_bus("wr resp");
    cycle();  // IDLE
    check("wr idle valid", rsp_valid, 1'b0);
    check("wr idle ready", cmd_ready, 1'b1);

    // ---------------- read with 3 wait states ----------------
    tim_pready = 1'b0;
    tim_prdata = 32'h0000_0003;
    issue(1'b0, 32'h4000_1000, 32'hFFFF_FFFF, 4'hF);
    cycle();  // SETUP
    cmd_valid = 1'b0;
    check("rd setup paddr",  tim_paddr,  32'h4000_1000);
    check("rd setup pwrite", tim_pwrite, 1'b0);
    check("rd setup pstrb",  tim_pstrb,  4'h0);
    check("rd setup pwdata", tim_pwdata, 32'h0);
    cycle();  // first ACCESS cycle
    for (int k = 0; k < 4; k++) begin
      check("rd access psel",    tim_psel,    1'b1);
      check("rd access penable", tim_penable, 1'b1);
      check("rd access paddr",   tim_paddr,   32'h4000_1000);
      check("rd access rvalid",  rsp_valid,   1'b0);
      if (k == 3) tim_pready = 1'b1;
      cycle();
    end
    tim_pready = 1'b0;
    check("rd resp valid", rsp_valid,   1'b1);
    check("rd resp rdata", rsp_rdata,   32'h0000_0003);
    check("rd resp err",   rsp_err,     1'b0);
    check("rd resp tout",  rsp_timeout, 1'b0);
    cycle();
    check("rd idle valid", rsp_valid, 1'b0);

    // ---------------- pslverr ignored without pready ----------------
    tim_prdata  = 32'h1122_3344;
    tim_pslverr = 1'b1;
    issue(1'b0, 32'h4000_2000, 32'h0, 4'h0);
    cycle();  // SETUP
    cmd_valid = 1'b0;
    cycle();  // ACCESS, pready=0 with pslverr=1
    tim_pready  = 1'b1;
    tim_pslverr = 1'b0;
    cycle();  // RESP
    tim_pready = 1'b0;
    check("ign resp valid", rsp_valid, 1'b1);
    check("ign resp err",   rsp_err,   1'b0);
    check("ign resp rdata", rsp_rdata, 32'h1122_3344);
    cycle();

    // ---------------- read with slave error ----------------
    tim_prdata  = 32'hDEAD_BEEF;
    tim_pready  = 1'b1;
    tim_pslverr = 1'b1;
    issue(1'b0, 32'h4000_3000, 32'h0, 4'h0);
    cycle();
    cmd_valid = 1'b0;
    cycle();
    cycle();  // RESP
    check("slv resp valid", rsp_valid,   1'b1);
    check("slv resp err",   rsp_err,     1'b1);
    check("slv resp tout",  rsp_timeout, 1'b0);
    check("slv resp rdata", rsp_rdata,   32'hDEAD_BEEF);
    tim_pslverr = 1'b0;
    cycle();

    // ---------------- write keeps rsp_rdata ----------------
    tim_prdata = 32'h0BAD_0BAD;
    issue(1'b1, 32'h4000_4000, 32'h0000_00FF, 4'h3);
    cycle();
    cmd_valid = 1'b0;
    check("wr2 setup pstrb", tim_pstrb, 4'h3);
    cycle();
    cycle();  // RESP
    check("wr2 resp valid", rsp_valid, 1'b1);
    check("wr2 resp err",   rsp_err,   1'b0);
    check("wr2 resp rdata", rsp_rdata, 32'hDEAD_BEEF);
    cycle();

    // ---------------- misaligned read ----------------
    issue(1'b0, 32'h4000_1002, 32'h0, 4'h0);
    cycle();  // straight to RESP
    cmd_valid = 1'b0;
    check("mis resp valid", rsp_valid,   1'b1);
    check("mis resp err",   rsp_err,     1'b1);
    check("mis resp tout",  rsp_timeout, 1'b0);
    check("mis resp rdata", rsp_rdata,   32'hDEAD_BEEF);
    check_idle_bus("mis resp");
    cycle();
    check("mis idle valid", rsp_valid, 1'b0);
    check("mis idle psel",  tim_psel,  1'b0);
    check("mis idle ready", cmd_ready, 1'b1);

    // ---------------- stalled slave ----------------
    tim_pready = 1'b0;
    tim_prdata = 32'h0000_0055;
    issue(1'b0, 32'h4000_5000, 32'h0, 4'h0);
    cycle();  // SETUP
    cmd_valid = 1'b0;
    cycle();  // ACCESS 1
    for (int k = 0; k < 4; k++) begin
      check("stall access psel",   tim_psel,  1'b1);
      check("stall access rvalid", rsp_valid, 1'b0);
      cycle();
    end
`ifdef APB_TIMEOUT_EN
    // 4 ACCESS cycles elapsed without pready: abort.
    check("tout resp valid", rsp_valid,   1'b1);
    check("tout resp err",   rsp_err,     1'b1);
    check("tout resp tout",  rsp_timeout, 1'b1);
    check("tout resp rdata", rsp_rdata,   32'hDEAD_BEEF);
    check_idle_bus("tout resp");
    tim_pready = 1'b1;  // late pready must not matter
    cycle();
    tim_pready = 1'b0;
    check("tout idle valid", rsp_valid, 1'b0);
    check("tout idle psel",  tim_psel,  1'b0);
    check("tout idle ready", cmd_ready, 1'b1);
`else
    // No timeout: still waiting after 4 ACCESS cycles, then 4 more.
    for (int k = 0; k < 4; k++) begin
      check("wait access psel",    tim_psel,    1'b1);
      check("wait access penable", tim_penable, 1'b1);
      check("wait access rvalid",  rsp_valid,   1'b0);
      cycle();
    end
    tim_pready = 1'b1;
    cycle();
    tim_pready = 1'b0;
    check("wait resp valid", rsp_valid,   1'b1);
    check("wait resp err",   rsp_err,     1'b0);
    check("wait resp tout",  rsp_timeout, 1'b0);
    check("wait resp rdata", rsp_rdata,   32'h0000_0055);
    cycle();
    check("wait idle ready", cmd_ready, 1'b1);
`endif

    // ---------------- reset during ACCESS ----------------
    tim_pready = 1'b0;
    issue(1'b1, 32'h4000_6000, 32'hCAFE_F00D, 4'hF);
    cycle();  // SETUP
    cmd_valid = 1'b0;
    cycle();  // ACCESS
    check("rstx access psel", tim_psel, 1'b1);
    #2;
    sys_rst = 1'b1;
    #1;  // still inside the same clock cycle
    check("rstx psel async",    tim_psel,    1'b0);
    check("rstx penable async", tim_penable, 1'b0);
    check("rstx paddr async",   tim_paddr,   32'h0);
    check("rstx ready held",    cmd_ready,   1'b0);
    cycle();
    sys_rst = 1'b0;
    #1;
    check("rstx rel ready", cmd_ready, 1'b1);
    check("rstx rel valid", rsp_valid, 1'b0);
    check("rstx rel rdata", rsp_rdata, 32'h0);
    tim_pready = 1'b1;
    cycle();
    check("rstx later valid", rsp_valid, 1'b0);
    check("rstx later psel",  tim_psel,  1'b0);

    // ---------------- back-to-back, cmd held valid ----------------
    issue(1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF);
    cycle();  // accept A -> SETUP
    cmd_addr  = 32'h0000_0200;
    cmd_wdata = 32'h2222_2222;
    check("b2b A setup paddr",  tim_paddr,  32'h0000_0100);
    check("b2b A setup pwdata", tim_pwdata, 32'h1111_1111);
    cycle();  // ACCESS
    check("b2b A access paddr", tim_paddr, 32'h0000_0100);
    cycle();  // RESP
    check("b2b A resp valid", rsp_valid, 1'b1);
    check("b2b A resp ready", cmd_ready, 1'b0);
    check("b2b A resp psel",  tim_psel,  1'b0);
    cycle();  // IDLE, accepts B at next edge
    check("b2b gap ready", cmd_ready, 1'b1);
    check("b2b gap valid", rsp_valid, 1'b0);
    cycle();  // SETUP for B
    cmd_valid = 1'b0;
    check("b2b B setup paddr",  tim_paddr,  32'h0000_0200);
    check("b2b B setup pwdata", tim_pwdata, 32'h2222_2222);
    cycle();
    cycle();  // RESP
    check("b2b B resp valid", rsp_valid, 1'b1);
    cycle();
    check("b2b end ready", cmd_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 255, maximum ACCESS-phase cycles before abort (only used with APB_TIMEOUT_EN).
REQ-002 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have port cmd_addr  input  32  byte address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port cmd_strb  input  4  write byte strobes.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata  output  32  read data, held until next response.
REQ-012 SHALL have port rsp_err  output  1  slave error, misalign or timeout.
REQ-013 SHALL have port rsp_timeout  output  1  response caused by timeout.
REQ-014 SHALL have ports tim_psel, tim_penable, tim_pwrite  output  1 each  APB control.
REQ-015 SHALL have ports tim_paddr, tim_pwdata  output  32 each; tim_pstrb  output  4.
REQ-016 SHALL have ports tim_prdata  input  32; tim_pready, tim_pslverr  input  1 each.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; at most one outstanding transfer.
REQ-019 IDLE, cmd_valid=1, cmd_addr[1:0]=0: capture command, go SETUP.
REQ-020 IDLE, cmd_valid=1, cmd_addr[1:0]!=0: no APB activity, go RESP with rsp_err=1, rsp_rdata unchanged.
REQ-021 SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb from captured command; exactly one cycle, then ACCESS.
REQ-022 ACCESS: psel=1, penable=1, all APB outputs held stable until tim_pready=1.
REQ-023 ACCESS with tim_pready=1: capture tim_prdata (reads only) and tim_pslverr, go RESP.
REQ-024 tim_pslverr SHALL be ignored when tim_pready=0.
REQ-025 tim_pstrb SHALL be 4'b0000 during reads; tim_pwdata SHALL be 0 during reads.
REQ-026 RESP: psel=0, penable=0, rsp_valid=1 for exactly one cycle, then IDLE.
REQ-027 Zero-wait-state slave: accept at edge N, SETUP cycle N+1, ACCESS N+2, rsp_valid N+3; next cmd_ready N+4.
REQ-028 Write responses SHALL leave rsp_rdata unchanged; read with pslverr=1 SHALL still update rsp_rdata.
REQ-029 tim_paddr, tim_pwdata, tim_pstrb, tim_pwrite SHALL be 0 in IDLE and RESP.
REQ-030 Changes on cmd_* after acceptance SHALL not affect the transfer in progress.

Reset
REQ-031 sys_rst=1 SHALL immediately force IDLE and all outputs to 0 except cmd_ready, which SHALL be 1 once sys_rst deasserts.
REQ-032 Reset mid-transfer SHALL abort without a response; psel/penable drop asynchronously.

Configuration
REQ-033 Macro APB_TIMEOUT_EN defined: a counter SHALL count ACCESS cycles; if tim_pready has not been seen after TIMEOUT_CYC ACCESS cycles, go RESP with rsp_err=1, rsp_timeout=1; late pready is ignored.
REQ-034 Counter SHALL clear on entry to SETUP; tim_pready=1 on the final allowed cycle completes normally (no timeout).
REQ-035 Macro undefined: no counter; ACCESS waits indefinitely; rsp_timeout tied 0.

Verification
REQ-036 Write 0x4000_1004 data 0xA5A5_5A5A strb 4'hF, pready=1 immediately -> SETUP/ACCESS one cycle each, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-037 Read 0x4000_1000, pready after 3 wait cycles, prdata 0x0000_0003 -> APB signals stable 4 ACCESS cycles, rsp_rdata=0x0000_0003.
REQ-038 Read with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0; read cmd_addr 0x4000_1002 -> no psel, rsp_err=1.
REQ-039 APB_TIMEOUT_EN, TIMEOUT_CYC=4, pready held 0 -> rsp_err=1, rsp_timeout=1 after 4 ACCESS cycles; pready on 4th cycle -> normal completion.
REQ-040 sys_rst pulsed during ACCESS -> psel/penable 0 in same cycle, no rsp_valid, cmd_ready=1 after release.
REQ-041 Back-to-back commands held valid -> each transfer separated by RESP cycle; captured address unaffected by cmd_addr change mid-transfer.
